regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Architectural register file and writeback tracer sitting directly downstream of instruction decode: consumes the decoded `rd`/`rs1`/`rs2` indices (`regindex_bits` wide) and supplies operands to execute. Tracks in-flight destinations with a busy scoreboard and stalls operand reads on hazards. Emits every committed writeback on the 36-bit trace interface as a two-beat record.

## Interface
Parameters:
- `ENABLE_REGS_16_31`, 1: registers x16–x31 present.
- `ENABLE_IRQ`, 0: IRQ support present.
- `ENABLE_IRQ_QREGS`, 1: four IRQ q-registers appended after the GPRs (effective only with `ENABLE_IRQ`).
- Derived, not overridable:
  - `regfile_size` = (`ENABLE_REGS_16_31` ? 32 : 16) + 4·`ENABLE_IRQ`·`ENABLE_IRQ_QREGS`.
  - `regindex_bits` = (`ENABLE_REGS_16_31` ? 5 : 4) + `ENABLE_IRQ`·`ENABLE_IRQ_QREGS`.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `iss_valid` in 1: an instruction with destination `iss_rd` issues this cycle.
- `iss_rd` in `regindex_bits`: destination index to mark busy.
- `rd_valid` in 1: operand read request.
- `rd_ready` out 1: read accepted this cycle; no hazard on `rs1`/`rs2`.
- `rs1`, `rs2` in `regindex_bits`: source indices.
- `rdata_valid` out 1: one-cycle pulse; `rdata1`/`rdata2` valid.
- `rdata1`, `rdata2` out 32: operand data.
- `wr_valid` in 1: writeback commit.
- `wr_idx` in `regindex_bits`, `wr_data` in 32: writeback index and data.
- `trace_valid` out 1: trace beat valid.
- `trace_data` out 36: trace beat.
- `trace_overflow` out 1: sticky; a trace record was dropped.

## Operation
- Storage: `regfile_size` × 32 flops, cleared to 0 on reset. Index 0 reads 0, is never written and is never busy.
- Out-of-range index (≥ `regfile_size`):
  - Reads return 0 and are never busy.
  - Writes are ignored and produce no trace.
  - Issue marks nothing busy.
- Scoreboard: one busy bit per register.
  - `iss_valid` sets `busy[iss_rd]`; `wr_valid` clears `busy[wr_idx]`.
  - Same index issued and written in one cycle: set wins and the bit stays busy.
- Hazard: `rs1` or `rs2` is busy and not forwarded (see Configuration). `rd_ready` = !hazard, independent of `rd_valid`.
- Read accepted when `rd_valid && rd_ready`. Operands are sampled from the array, or from `wr_data` when forwarded.
- Trace FSM states:
  - IDLE → IDX when a record is pending.
  - IDX → DATA unconditionally.
  - DATA → IDX if another record is pending, else IDLE.
  - Beat IDX: `{4'h1, 26'b0, wr_idx zero-extended to 6}`.
  - Beat DATA: `{4'h2, wr_data}`.
- Trace buffering: one-record holding register plus the record in flight.
  - A write arriving with the holding register full and the FSM not freeing it that cycle is dropped from trace; the register file is still updated.
  - A drop sets `trace_overflow`, which clears only on reset.
- Writes to x0 produce no trace.

## Timing
- Reset values:
  - `rd_ready`=1, `rdata_valid`=0, `rdata1`/`rdata2`=0.
  - `trace_valid`=0, `trace_data`=0, `trace_overflow`=0.
  - FSM in IDLE, all busy bits clear.
- Read latency: accepted in cycle N → `rdata_valid`=1 with data in N+1, for one cycle. Data holds until the next accept.
- Write latency: array updates at the end of cycle N. A read accepted at N+1 sees the new value.
- Trace latency: write commits in cycle N → IDX beat at N+1, DATA beat at N+2.
- Back-to-back writes at N and N+1 → beats at N+1 through N+4 with no gap.
- Reset asserted mid-operation: all state, including pending trace records, is discarded immediately.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A source matching a same-cycle `wr_valid`/`wr_idx` (nonzero, in range) is not a hazard.
  - Its operand is `wr_data`.
- Undefined:
  - `rd_ready` stays low in the write cycle.
  - The read is accepted the following cycle from the array (one extra stall cycle).

## Test plan
- Reset, then read x0/x5 → `rd_ready`=1; next cycle `rdata_valid`=1, `rdata1`=0, `rdata2`=0.
- Issue `rd`=7; read `rs1`=7 → `rd_ready`=0 until writeback.
  - Write 0xDEADBEEF to x7, with a read of 7 in the same cycle.
  - With bypass: accepted that cycle, `rdata1`=0xDEADBEEF.
  - Without bypass: accepted next cycle, same data.
- Write 0x12345678 to x3 at cycle N → trace 0x100000003 at N+1, 0x212345678 at N+2.
- Three writes on consecutive cycles → six contiguous beats; 4th consecutive write → `trace_overflow`=1, its register still updated.
- Write to x0 and to an out-of-range index → no trace, reads return 0.
- Assert `resetn` low while a trace beat and a busy bit are pending → `trace_valid`=0 and `rd_ready`=1 immediately.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// Architectural register file with a busy-bit scoreboard and a writeback
// tracer. Sits after decode: marks issued destinations busy, stalls operand
// reads that depend on an in-flight destination, and reports every committed
// writeback as a two-beat record on a 36-bit trace port.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - a source matching the same-cycle writeback is forwarded from
//               wr_data and does not stall.
//   undefined - such a source stalls for the write cycle and is read from
//               the array on the following cycle.
//
// Ports:
//   clk, resetn                 clock (rising edge), async active-low reset
//   iss_valid, iss_rd           issue: mark iss_rd busy
//   rd_valid, rs1, rs2          operand read request
//   rd_ready                    no hazard on rs1/rs2 (independent of rd_valid)
//   rdata_valid, rdata1, rdata2 operand data, pulse one cycle after accept
//   wr_valid, wr_idx, wr_data   writeback commit
//   trace_valid, trace_data     trace beats: {4'h1,26'b0,idx6} then {4'h2,data}
//   trace_overflow              sticky: a trace record was dropped
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int  ENABLE_REGS_16_31 = 1,
  parameter int  ENABLE_IRQ        = 0,
  parameter int  ENABLE_IRQ_QREGS  = 1,
  localparam int regfile_size      = ((ENABLE_REGS_16_31 != 0) ? 32 : 16)
                                     + 4 * ENABLE_IRQ * ENABLE_IRQ_QREGS,
  localparam int regindex_bits     = ((ENABLE_REGS_16_31 != 0) ? 5 : 4)
                                     + ENABLE_IRQ * ENABLE_IRQ_QREGS
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     iss_valid,
  input  logic [regindex_bits-1:0] iss_rd,
  input  logic                     rd_valid,
  output logic                     rd_ready,
  input  logic [regindex_bits-1:0] rs1,
  input  logic [regindex_bits-1:0] rs2,
  output logic                     rdata_valid,
  output logic [31:0]              rdata1,
  output logic [31:0]              rdata2,
  input  logic                     wr_valid,
  input  logic [regindex_bits-1:0] wr_idx,
  input  logic [31:0]              wr_data,
  output logic                     trace_valid,
  output logic [35:0]              trace_data,
  output logic                     trace_overflow
);

  typedef enum logic [1:0] {
    TR_IDLE,
    TR_IDX,
    TR_DATA
  } trace_state_e;

  // Index 0 and anything past the implemented registers behave as "no
  // register": never written, never busy, read as zero.
  function automatic logic idx_ok(input logic [regindex_bits-1:0] idx);
    return (idx != '0) && (int'(idx) < regfile_size);
  endfunction

  logic [31:0]              regs_q [regfile_size];
  logic [31:0]              regs_d [regfile_size];
  logic [regfile_size-1:0]  busy_q, busy_d;
  logic                     rdata_valid_q, rdata_valid_d;
  logic [31:0]              rdata1_q, rdata1_d;
  logic [31:0]              rdata2_q, rdata2_d;

  trace_state_e             state_q, state_d;
  logic [regindex_bits-1:0] cur_idx_q, cur_idx_d;
  logic [31:0]              cur_data_q, cur_data_d;
  logic                     hold_valid_q, hold_valid_d;
  logic [regindex_bits-1:0] hold_idx_q, hold_idx_d;
  logic [31:0]              hold_data_q, hold_data_d;
  logic                     overflow_q, overflow_d;

  logic wr_ok, iss_ok;
  logic fwd1, fwd2;
  logic haz1, haz2;
  logic accept;
  logic [31:0] op1, op2;
  logic [5:0] idx6;

  assign wr_ok  = wr_valid && idx_ok(wr_idx);
  assign iss_ok = iss_valid && idx_ok(iss_rd);

`ifdef REGFILE_BYPASS_EN
  assign fwd1 = wr_ok && (wr_idx == rs1);
  assign fwd2 = wr_ok && (wr_idx == rs2);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // Hazard detection and operand selection. A forwarded source never stalls
  // because its value is on wr_data this very cycle.
  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    op1  = '0;
    op2  = '0;
    if (idx_ok(rs1)) begin
      haz1 = busy_q[rs1] && !fwd1;
      op1  = fwd1 ? wr_data : regs_q[rs1];
    end
    if (idx_ok(rs2)) begin
      haz2 = busy_q[rs2] && !fwd2;
      op2  = fwd2 ? wr_data : regs_q[rs2];
    end
  end

  assign rd_ready = !(haz1 || haz2);
  assign accept   = rd_valid && rd_ready;

  // Register array, scoreboard and operand registers. The busy set is
  // applied after the clear so an issue to the index being written keeps
  // the register busy for the new producer.
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[wr_idx] = wr_data;
    end
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr_idx] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[iss_rd] = 1'b1;
    end
    rdata_valid_d = accept;
    rdata1_d      = accept ? op1 : rdata1_q;
    rdata2_d      = accept ? op2 : rdata2_q;
  end

  // Trace FSM next state. In IDLE or DATA the FSM is free to launch a record:
  // the holding register goes first (freeing it for a same-cycle write),
  // otherwise a new write launches directly so it appears one cycle later.
  // In IDX a new write can only be parked in the holding register; if that
  // is occupied the record is lost and the overflow flag latches.
  always_comb begin
    state_d      = state_q;
    cur_idx_d    = cur_idx_q;
    cur_data_d   = cur_data_q;
    hold_valid_d = hold_valid_q;
    hold_idx_d   = hold_idx_q;
    hold_data_d  = hold_data_q;
    overflow_d   = overflow_q;
    case (state_q)
      TR_IDLE, TR_DATA: begin
        if (hold_valid_q) begin
          state_d      = TR_IDX;
          cur_idx_d    = hold_idx_q;
          cur_data_d   = hold_data_q;
          hold_valid_d = wr_ok;
          if (wr_ok) begin
            hold_idx_d  = wr_idx;
            hold_data_d = wr_data;
          end
        end else if (wr_ok) begin
          state_d    = TR_IDX;
          cur_idx_d  = wr_idx;
          cur_data_d = wr_data;
        end else begin
          state_d = TR_IDLE;
        end
      end
      TR_IDX: begin
        state_d = TR_DATA;
        if (wr_ok) begin
          if (!hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_idx_d   = wr_idx;
            hold_data_d  = wr_data;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      default: state_d = TR_IDLE;
    endcase
  end

  // Trace beat outputs decoded from the current state.
  always_comb begin
    idx6        = 6'(cur_idx_q);
    trace_valid = 1'b0;
    trace_data  = '0;
    case (state_q)
      TR_IDX: begin
        trace_valid = 1'b1;
        trace_data  = {4'h1, 26'b0, idx6};
      end
      TR_DATA: begin
        trace_valid = 1'b1;
        trace_data  = {4'h2, cur_data_q};
      end
      default: ;
    endcase
  end

  // State registers; reset discards everything including pending records.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < regfile_size; i++) begin
        regs_q[i] <= '0;
      end
      busy_q        <= '0;
      rdata_valid_q <= 1'b0;
      rdata1_q      <= '0;
      rdata2_q      <= '0;
      state_q       <= TR_IDLE;
      cur_idx_q     <= '0;
      cur_data_q    <= '0;
      hold_valid_q  <= 1'b0;
      hold_idx_q    <= '0;
      hold_data_q   <= '0;
      overflow_q    <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      rdata_valid_q <= rdata_valid_d;
      rdata1_q      <= rdata1_d;
      rdata2_q      <= rdata2_d;
      state_q       <= state_d;
      cur_idx_q     <= cur_idx_d;
      cur_data_q    <= cur_data_d;
      hold_valid_q  <= hold_valid_d;
      hold_idx_q    <= hold_idx_d;
      hold_data_q   <= hold_data_d;
      overflow_q    <= overflow_d;
    end
  end

  assign rdata_valid    = rdata_valid_q;
  assign rdata1         = rdata1_q;
  assign rdata2         = rdata2_q;
  assign trace_overflow = overflow_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Directed bench for regfile_scoreboard, built with the IRQ q-registers
// enabled (36 registers, 6-bit indices) so out-of-range indices exist.
// Stimulus pushes expected read results and trace beats, each tagged with
// the cycle they must appear in, onto queues; a monitor on the falling edge
// pops and compares whenever rdata_valid or trace_valid is seen.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

  typedef struct {
    int          cyc;
    logic [31:0] d1;
    logic [31:0] d2;
  } read_t;

  typedef struct {
    int          cyc;
    logic [35:0] val;
  } beat_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iss_valid = 1'b0;
  logic [5:0]  iss_rd = '0;
  logic        rd_valid = 1'b0;
  logic        rd_ready;
  logic [5:0]  rs1 = '0;
  logic [5:0]  rs2 = '0;
  logic        rdata_valid;
  logic [31:0] rdata1, rdata2;
  logic        wr_valid = 1'b0;
  logic [5:0]  wr_idx = '0;
  logic [31:0] wr_data = '0;
  logic        trace_valid;
  logic [35:0] trace_data;
  logic        trace_overflow;

  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  read_t expReads[$];
  beat_t expBeats[$];

  regfile_scoreboard #(
    .ENABLE_REGS_16_31(1),
    .ENABLE_IRQ       (1),
    .ENABLE_IRQ_QREGS (1)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .iss_valid     (iss_valid),
    .iss_rd        (iss_rd),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rs1           (rs1),
    .rs2           (rs2),
    .rdata_valid   (rdata_valid),
    .rdata1        (rdata1),
    .rdata2        (rdata2),
    .wr_valid      (wr_valid),
    .wr_idx        (wr_idx),
    .wr_data       (wr_data),
    .trace_valid   (trace_valid),
    .trace_data    (trace_data),
    .trace_overflow(trace_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic iv, input logic [5:0] ird,
                               input logic rv, input logic [5:0] r1,
                               input logic [5:0] r2, input logic wv,
                               input logic [5:0] wi, input logic [31:0] wd);
    @(posedge clk);
    #1;
    iss_valid = iv;
    iss_rd    = ird;
    rd_valid  = rv;
    rs1       = r1;
    rs2       = r2;
    wr_valid  = wv;
    wr_idx    = wi;
    wr_data   = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0);
    end
  endtask

  task automatic checkReady(input string name, input logic expected);
    #2;
    checkOutput(name, {63'b0, rd_ready}, {63'b0, expected});
  endtask

  task automatic checkOverflow(input string name, input logic expected);
    #2;
    checkOutput(name, {63'b0, trace_overflow}, {63'b0, expected});
  endtask

  task automatic pushRead(input int c, input logic [31:0] d1, input logic [31:0] d2);
    read_t r;
    r.cyc = c;
    r.d1  = d1;
    r.d2  = d2;
    expReads.push_back(r);
  endtask

  task automatic pushBeat(input int c, input logic [35:0] v);
    beat_t b;
    b.cyc = c;
    b.val = v;
    expBeats.push_back(b);
  endtask

  task automatic pushTrace(input int c, input logic [5:0] idx, input logic [31:0] d);
    pushBeat(c, {4'h1, 26'b0, idx});
    pushBeat(c + 1, {4'h2, d});
  endtask

  // Monitor: compares every presented output against the queue heads.
  always @(negedge clk) begin
    read_t re;
    beat_t be;
    if (resetn) begin
      if (rdata_valid) begin
        if (expReads.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_rdata: got rdata1=0x%0h rdata2=0x%0h at cycle %0d, required no read", rdata1, rdata2, cyc);
        end else begin
          re = expReads.pop_front();
          checkOutput("rdata_cycle", 64'(cyc), 64'(re.cyc));
          checkOutput("rdata1", {32'b0, rdata1}, {32'b0, re.d1});
          checkOutput("rdata2", {32'b0, rdata2}, {32'b0, re.d2});
        end
      end
      if (trace_valid) begin
        if (expBeats.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_trace: got 0x%0h at cycle %0d, required no beat", trace_data, cyc);
        end else begin
          be = expBeats.pop_front();
          checkOutput("trace_cycle", 64'(cyc), 64'(be.cyc));
          checkOutput("trace_data", {28'b0, trace_data}, {28'b0, be.val});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    #2;
    checkOutput("reset_rd_ready", {63'b0, rd_ready}, 64'd1);
    checkOutput("reset_rdata_valid", {63'b0, rdata_valid}, 64'd0);
    checkOutput("reset_rdata1", {32'b0, rdata1}, 64'd0);
    checkOutput("reset_rdata2", {32'b0, rdata2}, 64'd0);
    checkOutput("reset_trace_valid", {63'b0, trace_valid}, 64'd0);
    checkOutput("reset_trace_data", {28'b0, trace_data}, 64'd0);
    checkOutput("reset_overflow", {63'b0, trace_overflow}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Read x0/x5 straight after reset
    applyStimulus(1'b0, 6'd0, 1'b1, 6'd0, 6'd5, 1'b0, 6'd0, 32'h0);
    pushRead(cyc + 1, 32'h0, 32'h0);
    checkReady("ready_x0_x5", 1'b1);
    idle(1);

    // Write x3 then read it back
    applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b1, 6'd3, 32'h12345678);
    pushTrace(cyc + 1, 6'd3, 32'h12345678);
    idle(2);
    applyStimulus(1'b0, 6'd0, 1'b1, 6'd3, 6'd0, 1'b0, 6'd0, 32'h0);
    pushRead(cyc + 1, 32'h12345678, 32'h0);
    checkReady("ready_x3", 1'b1);
    idle(1);

    // Issue x7, stall reads of x7 until writeback
    applyStimulus(1'b1, 6'd7, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0);
    applyStimulus(1'b0, 6'd0, 1'b1, 6'd7, 6'd3, 1'b0, 6'd0, 32'h0);
    checkReady("ready_busy_x7", 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0, 6'd7, 6'd3, 1'b0, 6'd0, 32'h0);
    checkReady("ready_busy_no_valid", 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b1, 6'd7, 6'd3, 1'b1, 6'd7, 32'hDEADBEEF);
    pushTrace(cyc + 1, 6'd7, 32'hDEADBEEF);
`ifdef REGFILE_BYPASS_EN
    pushRead(cyc + 1, 32'hDEADBEEF, 32'h12345678);
    checkReady("ready_bypass_write_cycle", 1'b1);
`else
    checkReady("ready_write_cycle", 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b1, 6'd7, 6'd3, 1'b0, 6'd0, 32'h0);
    pushRead(cyc + 1, 32'hDEADBEEF, 32'h12345678);
    checkReady("ready_after_write", 1'b1);
`endif
    idle(2);

    // Issue and write x9 in one cycle: set wins, x9 stays busy
    applyStimulus(1'b1, 6'd9, 1'b0, 6'd0, 6'd0, 1'b1, 6'd9, 32'h00000099);
    pushTrace(cyc + 1, 6'd9, 32'h00000099);
    applyStimulus(1'b0, 6'd0, 1'b1, 6'd9, 6'd0, 1'b0, 6'd0, 32'h0);
    checkReady("ready_set_wins", 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b1, 6'd9, 32'h0000009A);
    pushTrace(cyc + 1, 6'd9, 32'h0000009A);
    applyStimulus(1'b0, 6'd0, 1'b1, 6'd9, 6'd0, 1'b0, 6'd0, 32'h0);
    pushRead(cyc + 1, 32'h0000009A, 32'h0);
    checkReady("ready_x9_cleared", 1'b1);
    idle(3);

    // Out-of-range issue marks nothing busy
    applyStimulus(1'b1, 6'd40, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0);
    applyStimulus(1'b0, 6'd0, 1'b1, 6'd40, 6'd0, 1'b0, 6'd0, 32'h0);
    pushRead(cyc + 1, 32'h0, 32'h0);
    checkReady("ready_oor_issue", 1'b1);
    idle(1);

    // Four consecutive writes: three traced back to back, fourth dropped
    applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b1, 6'd10, 32'hA0A00010);
    pushTrace(cyc + 1, 6'd10, 32'hA0A00010);
    pushTrace(cyc + 3, 6'd11, 32'hA0A00011);
    pushTrace(cyc + 5, 6'd12, 32'hA0A00012);
    applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b1, 6'd11, 32'hA0A00011);
    applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b1, 6'd12, 32'hA0A00012);
    applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b1, 6'd13, 32'hA0A00013);
    checkOverflow("overflow_before_drop", 1'b0);
    idle(1);
    checkOverflow("overflow_set", 1'b1);
    idle(4);
    applyStimulus(1'b0, 6'd0, 1'b1, 6'd10, 6'd11, 1'b0, 6'd0, 32'h0);
    pushRead(cyc + 1, 32'hA0A00010, 32'hA0A00011);
    applyStimulus(1'b0, 6'd0, 1'b1, 6'd12, 6'd13, 1'b0, 6'd0, 32'h0);
    pushRead(cyc + 1, 32'hA0A00012, 32'hA0A00013);
    idle(2);
    checkOverflow("overflow_sticky", 1'b1);

    // Writes to x0 and out of range are silent; q-register x35 is traced
    applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b1, 6'd0, 32'hFFFFFFFF);
    applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b1, 6'd40, 32'hAAAAAAAA);
    applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b1, 6'd35, 32'h35353535);
    pushTrace(cyc + 1, 6'd35, 32'h35353535);
    idle(2);
    applyStimulus(1'b0, 6'd0, 1'b1, 6'd0, 6'd40, 1'b0, 6'd0, 32'h0);
    pushRead(cyc + 1, 32'h0, 32'h0);
    applyStimulus(1'b0, 6'd0, 1'b1, 6'd35, 6'd0, 1'b0, 6'd0, 32'h0);
    pushRead(cyc + 1, 32'h35353535, 32'h0);
    idle(2);

    // Reset while a trace record and a busy bit are pending
    applyStimulus(1'b1, 6'd20, 1'b0, 6'd0, 6'd0, 1'b1, 6'd21, 32'h21212121);
    pushBeat(cyc + 1, {4'h1, 26'b0, 6'd21});
    applyStimulus(1'b0, 6'd0, 1'b1, 6'd20, 6'd0, 1'b0, 6'd0, 32'h0);
    checkReady("ready_busy_x20", 1'b0);
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("midreset_trace_valid", {63'b0, trace_valid}, 64'd0);
    checkOutput("midreset_trace_data", {28'b0, trace_data}, 64'd0);
    checkOutput("midreset_rd_ready", {63'b0, rd_ready}, 64'd1);
    checkOutput("midreset_overflow", {63'b0, trace_overflow}, 64'd0);
    rd_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(1'b0, 6'd0, 1'b1, 6'd21, 6'd20, 1'b0, 6'd0, 32'h0);
    pushRead(cyc + 1, 32'h0, 32'h0);
    checkReady("ready_after_reset", 1'b1);
    idle(4);

    checkOutput("read_queue_drained", 64'(expReads.size()), 64'd0);
    checkOutput("trace_queue_drained", 64'(expBeats.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
